forward_neuron: RTL

Sequential forward-pass neuron that computes one weighted sum of four 4-bit activations plus a bias and hands the 23-bit result to the backprop stage downstream. One multiply-accumulate step per cycle over an internal FSM. The result is presented with a valid/ready handshake and held stable until consumed. The captured 4-bit training target travels with the result so backprop sees a matched pair.

---
 rtl/nn_pkg.sv | 26 ++
 rtl/fwd_mac_unit.sv | 47 ++++
 rtl/forward_neuron.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the forward-pass neuron slice.
//   - datapath widths: activation, weight, product, accumulator, result
//   - operand index width for the MAC sequencer
//   - FSM state encoding used by forward_neuron
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

   localparam int ACT_W    = 4;   // unsigned activation width
   localparam int WGT_W    = 8;   // signed weight / bias width
   localparam int PROD_W   = 12;  // signed weight x unsigned activation product
   localparam int ACCUM_W  = 15;  // |acc| <= 9728, so 15 signed bits never overflow
   localparam int RESULT_W = 23;  // width expected by the backprop stage
   localparam int IDX_W    = 2;   // index over the four operand pairs
   localparam int BIAS_SH  = 4;   // bias is aligned to the product scale by << 4

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_BIAS = 2'd2,
      ST_HOLD = 2'd3
   } fwd_state_e;

endpackage : nn_pkg

// File: rtl/fwd_mac_unit.sv
// -----------------------------------------------------------------------------
// fwd_mac_unit
// Combinational multiply-accumulate step for the forward neuron.
// Computes o_sum = i_acc + addend, where addend is either the signed product
// sext(i_wgt) * zext(i_act), or the shifted bias sext(i_bias) << 4 when
// i_bias_sel is high. One adder therefore serves both the MAC and BIAS steps.
//
// Ports:
//   i_wgt      in  8   signed weight of the current pair
//   i_act      in  4   unsigned activation of the current pair
//   i_bias     in  8   signed bias
//   i_bias_sel in  1   1: add the shifted bias instead of the product
//   i_acc      in  15  signed running accumulator
//   o_sum      out 15  signed updated accumulator value
// -----------------------------------------------------------------------------
module fwd_mac_unit
   import nn_pkg::*;
(
   input  logic signed [WGT_W-1:0]   i_wgt,
   input  logic        [ACT_W-1:0]   i_act,
   input  logic signed [WGT_W-1:0]   i_bias,
   input  logic                      i_bias_sel,
   input  logic signed [ACCUM_W-1:0] i_acc,
   output logic signed [ACCUM_W-1:0] o_sum
);

   logic signed [PROD_W-1:0]  w_wgt_x;
   logic signed [PROD_W-1:0]  w_act_x;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACCUM_W-1:0] w_prod_x;
   logic signed [ACCUM_W-1:0] w_bias_x;
   logic signed [ACCUM_W-1:0] w_addend;

   // Both operands are widened to the product width before multiplying so the
   // activation is treated as a non-negative value in a signed multiply.
   // -128 * 15 = -1920 is the extreme product and fits in 12 signed bits.
   assign w_wgt_x = {{(PROD_W-WGT_W){i_wgt[WGT_W-1]}}, i_wgt};
   assign w_act_x = {{(PROD_W-ACT_W){1'b0}}, i_act};
   assign w_prod  = w_wgt_x * w_act_x;

   assign w_prod_x = {{(ACCUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign w_bias_x = {{(ACCUM_W-WGT_W-BIAS_SH){i_bias[WGT_W-1]}}, i_bias, {BIAS_SH{1'b0}}};

   assign w_addend = i_bias_sel ? w_bias_x : w_prod_x;
   assign o_sum    = i_acc + w_addend;

endmodule : fwd_mac_unit

// File: rtl/forward_neuron.sv
// -----------------------------------------------------------------------------
// forward_neuron
// Sequential forward-pass neuron: result = sum_k sext(w_k)*zext(a_k)
// + (sext(bias) << 4), computed one MAC step per cycle and handed downstream
// with a valid/ready handshake. The training target captured with the
// operands is presented alongside the result so backprop sees a matched pair.
//
// Build option:
//   FWD_RELU_EN  defined   -> negative sums load final_o = 0 (ReLU)
//                undefined -> the signed sum is sign-extended unchanged
//
// Ports:
//   clk_i        in  1   clock
//   rst_i        in  1   asynchronous active-low reset
//   start_i      in  1   request a pass; accepted only while busy_o = 0
//   a0_i..a3_i   in  4   unsigned activations (sampled on acceptance)
//   w0_i..w3_i   in  8   signed weights (sampled on acceptance)
//   bias_i       in  8   signed bias (sampled on acceptance)
//   target_i     in  4   training target (sampled on acceptance)
//   busy_o       out 1   high from acceptance until the result handshake
//   valid_o      out 1   final_o / target_o valid
//   ready_i      in  1   downstream consumes the result when high with valid_o
//   final_o      out 23  signed result, sign-extended
//   target_o     out 4   target captured with this pass
// -----------------------------------------------------------------------------
module forward_neuron
   import nn_pkg::*;
#(
   parameter int N_IN  = 4,   // operand pairs; fixed at 4 in this revision
   parameter int ACC_W = 23   // result width seen by backprop
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic        [ACT_W-1:0] a0_i,
   input  logic        [ACT_W-1:0] a1_i,
   input  logic        [ACT_W-1:0] a2_i,
   input  logic        [ACT_W-1:0] a3_i,
   input  logic signed [WGT_W-1:0] w0_i,
   input  logic signed [WGT_W-1:0] w1_i,
   input  logic signed [WGT_W-1:0] w2_i,
   input  logic signed [WGT_W-1:0] w3_i,
   input  logic signed [WGT_W-1:0] bias_i,
   input  logic        [ACT_W-1:0] target_i,
   output logic                    busy_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic signed [ACC_W-1:0] final_o,
   output logic        [ACT_W-1:0] target_o
);

   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_IN - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   fwd_state_e r_state;
   fwd_state_e w_state_nxt;

   logic [N_IN-1:0][ACT_W-1:0]        r_act;
   logic [N_IN-1:0][WGT_W-1:0]        r_wgt;
   logic signed [WGT_W-1:0]           r_bias;
   logic        [ACT_W-1:0]           r_target;
   logic signed [ACCUM_W-1:0]         r_acc;
   logic        [IDX_W-1:0]           r_k;
   logic signed [ACC_W-1:0]           r_final;
   logic        [ACT_W-1:0]           r_target_out;

   logic                              w_accept;
   logic                              w_mac_step;
   logic                              w_bias_step;
   logic signed [ACCUM_W-1:0]         w_sum;
   logic signed [ACC_W-1:0]           w_sum_ext;
   logic signed [ACC_W-1:0]           w_final_nxt;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples pre-edge values regardless of process ordering.
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and step decodes
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mac_step  = 1'b0;
      w_bias_step = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_MAC;
            end
         end
         ST_MAC: begin
            w_mac_step = 1'b1;
            if (r_k == K_LAST) begin
               w_state_nxt = ST_BIAS;
            end
         end
         ST_BIAS: begin
            w_bias_step = 1'b1;
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy_o  = (r_state != ST_IDLE);
   assign valid_o = (r_state == ST_HOLD);

   // ---------------------------------------------------------------------------
   // Shared multiply-add: product of pair k in MAC, shifted bias in BIAS
   // ---------------------------------------------------------------------------
   fwd_mac_unit u_mac (
      .i_wgt      (r_wgt[r_k]),
      .i_act      (r_act[r_k]),
      .i_bias     (r_bias),
      .i_bias_sel (w_bias_step),
      .i_acc      (r_acc),
      .o_sum      (w_sum)
   );

   assign w_sum_ext = {{(ACC_W-ACCUM_W){w_sum[ACCUM_W-1]}}, w_sum};

`ifdef FWD_RELU_EN
   assign w_final_nxt = w_sum[ACCUM_W-1] ? '0 : w_sum_ext;
`else
   assign w_final_nxt = w_sum_ext;
`endif

   // ---------------------------------------------------------------------------
   // Operand capture, accumulator and result register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: the captured operand bank is reset along with the control
         // state; it is a handful of flops, not a RAM, so clearing it is cheap
         // and keeps every observable register deterministic after reset.
         r_act        <= '0;
         r_wgt        <= '0;
         r_bias       <= '0;
         r_target     <= '0;
         r_acc        <= '0;
         r_k          <= '0;
         r_final      <= '0;
         r_target_out <= '0;
      end else if (w_accept) begin
         r_act    <= {a3_i, a2_i, a1_i, a0_i};
         r_wgt    <= {w3_i, w2_i, w1_i, w0_i};
         r_bias   <= bias_i;
         r_target <= target_i;
         r_acc    <= '0;
         r_k      <= '0;
      end else if (w_mac_step) begin
         r_acc <= w_sum;
         r_k   <= r_k + 1'b1;
      end else if (w_bias_step) begin
         // Result and target are loaded together so they always form a pair;
         // both then hold until the next BIAS step.
         r_acc        <= w_sum;
         r_final      <= w_final_nxt;
         r_target_out <= r_target;
      end
   end

   assign final_o  = r_final;
   assign target_o = r_target_out;

endmodule : forward_neuron
